// File: rtl/seq_scan_pkg.sv
// rtl/seq_scan_pkg.sv - shared types and default constants for the serial scan controller
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } scan_state_t;

    localparam int                     DEF_WORD_W  = 8;
    localparam int                     DEF_PAT_LEN = 5;
    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 5'b10010;
    localparam int                     DEF_CNT_W   = 4;
    localparam int                     FILL_W      = $clog2(DEF_PAT_LEN);

endpackage

// File: rtl/pat_window_det.sv
// rtl/pat_window_det.sv - bit-serial sliding-window pattern detector with fill tracking
module pat_window_det
    import seq_scan_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_valid,
    input  logic bit_in,
    output logic hit
);

    localparam int             FW       = $clog2(PAT_LEN);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN - 1);

    logic [PAT_LEN-2:0] r_hist;
    logic [FW-1:0]      r_fill;
    logic [PAT_LEN-1:0] w_window;

    // Window is the stored history plus the bit presented this cycle, oldest bit at the MSB.
    assign w_window = {r_hist, bit_in};

    // Fill saturates at PAT_LEN-1, so equality means the history holds a full prefix.
    assign hit = bit_valid && (r_fill == FILL_MAX) && (w_window == PATTERN);

    // History and fill advance on every presented bit; a hit does not clear them so matches overlap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
        end else if (bit_valid) begin
            r_hist <= w_window[PAT_LEN-2:0];
            if (r_fill != FILL_MAX) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - word-to-serial scan controller; SEQ_SCAN_CARRY_STATE_EN keeps detector history across words
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int                 WORD_W  = DEF_WORD_W,
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              hit,
    output logic              busy
);

    localparam int                IDX_W    = $clog2(WORD_W);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    scan_state_t        r_state;
    scan_state_t        w_next_state;
    logic [WORD_W-1:0]  r_shreg;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [CNT_W-1:0]   r_match_cnt;
    logic               w_accept;
    logic               w_bit_valid;
    logic               w_det_clr;
    logic               w_hit;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_busy;

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign w_bit_valid = (r_state == SHIFT);

`ifdef SEQ_SCAN_CARRY_STATE_EN
    assign w_det_clr = 1'b0;
`else
    assign w_det_clr = w_accept;
`endif

    pat_window_det #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_det (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_det_clr),
        .bit_valid (w_bit_valid),
        .bit_in    (r_shreg[WORD_W-1]),
        .hit       (w_hit)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                w_busy = 1'b1;
                if (r_bit_idx == LAST_IDX) begin
                    w_next_state = REPORT;
                end
            end
            REPORT: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Word shift register, bit index and saturating match counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg     <= '0;
            r_bit_idx   <= '0;
            r_match_cnt <= '0;
        end else if (w_accept) begin
            r_shreg     <= in_word;
            r_bit_idx   <= '0;
            r_match_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (w_hit && (r_match_cnt != CNT_MAX)) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign busy      = w_busy;
    assign match_cnt = r_match_cnt;
    assign hit       = w_hit;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - directed self-checking bench for seq_scan_ctrl
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, hit, busy;
    logic [7:0]  in_word;
    logic [3:0]  match_cnt;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, hit2, busy2;
    logic [15:0] in_word2;
    logic [1:0]  match_cnt2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .match_cnt (match_cnt),
        .hit       (hit),
        .busy      (busy)
    );

    seq_scan_ctrl #(
        .WORD_W  (16),
        .PAT_LEN (3),
        .PATTERN (3'b100),
        .CNT_W   (2)
    ) u_dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_word   (in_word2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .match_cnt (match_cnt2),
        .hit       (hit2),
        .busy      (busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Accept one word at a negedge, record hit per bit cycle, check the report,
    // optionally hold off out_ready while poking in_valid, then complete.
    task automatic scan_word(input string tag, input logic [7:0] w,
                             input logic [3:0] exp_cnt, input logic [15:0] exp_mask,
                             input int hold);
        logic [15:0] mask;
        mask = '0;
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
        in_word  = w;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        for (int k = 1; k <= 8; k++) begin
            mask[k-1] = hit;
            @(negedge clk);
        end
        check({tag, "_ovld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_cnt"}, {28'd0, match_cnt}, {28'd0, exp_cnt});
        check({tag, "_hits"}, {16'd0, mask}, {16'd0, exp_mask});
        for (int c = 0; c < hold; c++) begin
            in_valid = c[0];
            in_word  = 8'hFF;
            @(negedge clk);
            check({tag, "_bp_ovld"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_bp_cnt"}, {28'd0, match_cnt}, {28'd0, exp_cnt});
            check({tag, "_bp_rdy"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = (hold > 0);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, "_idle_rdy"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_ovld"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic       seen_ovld;
        int         hits2;
        logic [3:0] exp_carry_cnt;
        logic [15:0] exp_carry_mask;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_word    = '0;
        out_ready  = 1'b0;
        in_valid2  = 1'b0;
        in_word2   = '0;
        out_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        check("rst_ovld", {31'd0, out_valid}, 32'd0);
        check("rst_cnt", {28'd0, match_cnt}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the fourth bit cycle abandons the word.
        in_word  = 8'b10010010;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen_ovld = 1'b0;
        for (int c = 0; c < 10; c++) begin
            seen_ovld = seen_ovld | out_valid;
            @(negedge clk);
        end
        check("mid_rst_no_ovld", {31'd0, seen_ovld}, 32'd0);
        check("mid_rst_cnt", {28'd0, match_cnt}, 32'd0);

        scan_word("w92", 8'b10010010, 4'd2, 16'h0090, 0);
        scan_word("wff", 8'hFF, 4'd0, 16'h0000, 0);
        scan_word("w12", 8'b00010010, 4'd1, 16'h0080, 0);

        scan_word("carry_a", 8'b00000100, 4'd0, 16'h0000, 0);
`ifdef SEQ_SCAN_CARRY_STATE_EN
        exp_carry_cnt  = 4'd1;
        exp_carry_mask = 16'h0002;
`else
        exp_carry_cnt  = 4'd0;
        exp_carry_mask = 16'h0000;
`endif
        scan_word("carry_b", 8'b10000000, exp_carry_cnt, exp_carry_mask, 0);

        scan_word("bp", 8'b10010010, 4'd2, 16'h0090, 10);

        // Saturating counter on the 16-bit, 3-bit-pattern instance.
        check("sat_rdy", {31'd0, in_ready2}, 32'd1);
        in_word2  = 16'h9249;
        in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        hits2 = 0;
        for (int k = 1; k <= 16; k++) begin
            hits2 += int'(hit2);
            @(negedge clk);
        end
        check("sat_ovld", {31'd0, out_valid2}, 32'd1);
        check("sat_cnt", {30'd0, match_cnt2}, 32'd3);
        check("sat_raw_hits", hits2, 32'd5);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        check("sat_idle", {31'd0, in_ready2}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
